// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the core, the multi-cycle mul/div sequencer and the shared ALU.
// The slave side is the sequencer. The master side is the environment: the core
// issues requests, and the ALU returns alu_c.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_c;

  modport master (
    output start, op, opa, opb, alu_c,
    input  busy, done, result, alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, op, opa, opb, alu_c,
    output busy, done, result, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M MUL (low word), DIVU and REMU sequencer.
// It performs one shift-add or restoring-divide step per cycle through the
// execute-stage ALU and holds the core off through busy until done pulses.
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_muldiv_seq_if.slave  bus
);

  localparam int             CW        = $clog2(ITER);
  localparam logic [CW-1:0]  LAST_ITER = CW'(ITER - 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The working registers are shared by both algorithms:
  //   r_a : MUL accumulator / divide partial remainder
  //   r_b : MUL multiplicand / divide quotient (starts as dividend)
  //   r_c : MUL multiplier   / divisor
  logic [1:0]      r_state;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_c;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic [XLEN-1:0] w_rs;
  logic            w_carry;
  logic            w_ge;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [4:0]      w_alu_op;
  logic [XLEN-1:0] w_a_nxt;
  logic [XLEN-1:0] w_b_nxt;
  logic [XLEN-1:0] w_c_nxt;
  logic [XLEN-1:0] w_result;

  // One iteration step: ALU drive plus next values of the working registers.
  always_comb begin
    // The shifted-in remainder can exceed 32 bits. The dropped top bit is kept
    // as a carry that forces the subtract.
    w_rs     = {r_a[XLEN-2:0], r_b[XLEN-1]};
    w_carry  = r_a[XLEN-1];
    w_ge     = w_carry | (w_rs >= r_c);
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = ALU_NOP;
    w_a_nxt  = r_a;
    w_b_nxt  = r_b;
    w_c_nxt  = r_c;
    if (r_state == S_RUN) begin
      if (r_op == OP_MUL) begin
        w_b_nxt = r_b << 1;
        w_c_nxt = r_c >> 1;
        if (r_c[0]) begin
          w_alu_a  = r_a;
          w_alu_b  = r_b;
          w_alu_op = ALU_ADD;
          w_a_nxt  = bus.alu_c;
        end else begin
          w_alu_op = ALU_NOP;
          w_a_nxt  = r_a;
        end
      end else begin
        w_alu_a  = w_rs;
        w_alu_b  = r_c;
        w_alu_op = ALU_SUB;
        if (w_ge) begin
          w_a_nxt = bus.alu_c;
          w_b_nxt = {r_b[XLEN-2:0], 1'b1};
        end else begin
          w_a_nxt = w_rs;
          w_b_nxt = {r_b[XLEN-2:0], 1'b0};
        end
      end
    end else begin
      w_alu_op = ALU_NOP;
    end
  end

  // Choose which working register becomes the result after the final step.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:  w_result = w_a_nxt;
      OP_DIVU: w_result = w_b_nxt;
      OP_REMU: w_result = w_a_nxt;
      default: w_result = '0;
    endcase
  end

  // Sequencer state, working registers and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op   <= bus.op;
            r_a    <= '0;
            r_b    <= bus.opa;
            r_c    <= bus.opb;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (bus.op == OP_RSVD) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= '0;
            end else if ((bus.op != OP_MUL) && (bus.opb == '0)) begin
              // Divide-by-zero results follow RISC-V: all ones, or the dividend.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= (bus.op == OP_DIVU) ? {XLEN{1'b1}} : bus.opa;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_b   <= w_b_nxt;
          r_c   <= w_c_nxt;
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == LAST_ITER) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_result;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.alu_a  = w_alu_a;
  assign bus.alu_b  = w_alu_b;
  assign bus.alu_op = w_alu_op;

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that computes RV32M MUL (low 32 bits), DIVU and REMU by reusing the single-cycle ALU's add and sub operations, one iteration per cycle.
- Drives the ALU's A/B/ALUOp inputs and consumes its C output. It sits beside the ALU in the execute stage and stalls the core through busy until done.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- ITER, 32, iterations per multiply/divide. Must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  operation: 00 MUL, 01 DIVU, 10 REMU, 11 reserved
- opa  input  32  multiplicand / dividend, captured on accepted start
- opb  input  32  multiplier / divisor, captured on accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  32  registered result, held until the next accepted start
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- alu_op  output  5  ALU opcode: nop 5'b00000, add 5'b00011, sub 5'b00100
- alu_c  input  32  ALU result, combinational from alu_a/alu_b/alu_op

Behaviour:
- Reset is synchronous and applies from any state. It forces state to IDLE and clears busy, done, result, the iteration counter and the internal registers to 0. An in-flight operation is discarded.
- States are IDLE, RUN and DONE.
- IDLE:
  - alu_op=nop; alu_a=alu_b=0.
  - If start is sampled at edge T, the block latches op, opa and opb.
  - If op=11, or op is DIVU/REMU with opb==0, the next state is DONE (fast path). Otherwise the next state is RUN with counter=0.
- RUN: lasts exactly ITER cycles, counter 0..31. After iteration 31 the next state is DONE.
- MUL iteration (regs acc=0, mcand=opa, mplier=opb at entry):
  - If mplier[0]=1: alu_a=acc, alu_b=mcand, alu_op=add, acc<=alu_c.
  - If mplier[0]=0: alu_op=nop and acc is unchanged.
  - Every cycle: mcand<<=1 and mplier>>=1 (logical). Overflow beyond 32 bits is discarded, so the result is the product modulo 2^32.
- DIVU/REMU iteration, restoring (regs rem=0, quo=opa, dvs=opb at entry):
  - Form rs={rem[30:0],quo[31]} and carry c=rem[31].
  - Drive alu_a=rs, alu_b=dvs, alu_op=sub.
  - If c=1 or rs>=dvs (unsigned, compared internally): rem<=alu_c and quo<={quo[30:0],1}.
  - Otherwise: rem<=rs and quo<={quo[30:0],0}.
- DONE: lasts one cycle with done=1 and busy=1; the next state is IDLE.
  - result is loaded on the edge entering DONE:
    - MUL: acc
    - DIVU: quo
    - REMU: rem
    - DIVU with opb=0: 0xFFFFFFFF
    - REMU with opb=0: opa
    - op=11: 0
  - result is stable during the done cycle and afterwards.
- Latency:
  - Normal path: start at edge T, RUN in cycles T+1..T+32, done high in cycle T+33.
  - Fast path: done high in cycle T+1.
  - Minimum spacing between accepted starts is 34 cycles (normal) or 2 cycles (fast).
- start while busy=1, including during the DONE cycle, is ignored and not queued.
- opa/opb/op changes after acceptance have no effect.
- The ALU Zero flag is not used.

Test Plan:
- MUL opa=7, opb=6, start at T -> busy in T+1..T+33; done only in T+33; result=42; alu_op=add only in cycles where mplier[0]=1.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001. MUL 0x00010000 x 0x00010000 -> result=0x00000000.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/0x80000001 -> 1 and REMU -> 0x7FFFFFFE (exercises the carry path).
- DIVU 5/0 -> done at T+1, result=0xFFFFFFFF. REMU 5/0 -> 5. op=11 -> done at T+1, result=0.
- Assert rst at RUN iteration 10 -> next cycle busy=0, done=0, result=0. A following MUL 3x5 returns 15 at T'+33.
- Pulse start again at T+5 and at T+33 during a MUL -> both ignored. A start at T+34 is accepted and its done occurs at T+67.
